vga_frame_scanner: RTL and testbench
====================================

VGA_FRAME_SCANNER -- requirements
Module: vga_frame_scanner

Interface
REQ-001 SHALL have parameter PIX_DIV, default 4, system clocks per pixel (100 MHz -> 25 MHz).
REQ-002 SHALL have parameter H_TOTAL, default 800, pixel periods per line.
REQ-003 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-004 SHALL have port CLK  input  1  system clock, single clock domain.
REQ-005 SHALL have port RESET_N  input  1  asynchronous active-low reset.
REQ-006 SHALL have port CONFIG_COLOURS  input  16  [15:8] foreground for pixel 1, [7:0] background for pixel 0.
REQ-007 SHALL have port VGA_DATA  input  1  frame-buffer read data, valid one CLK after VGA_ADDR.
REQ-008 SHALL have port VGA_ADDR  output  15  frame-buffer read address {Y[6:0], X[7:0]}.
REQ-009 SHALL have port VGA_HS  output  1  horizontal sync, active low.
REQ-010 SHALL have port VGA_VS  output  1  vertical sync, active low.
REQ-011 SHALL have port VGA_COLOUR  output  8  pixel colour, zero during blanking.
REQ-012 SHALL have port VBLANK_START  output  1  one-CLK pulse at start of vertical blanking.

Function
REQ-013 SHALL generate a pixel tick every PIX_DIV CLKs using a free-running divider; tick asserted when divider = PIX_DIV-1.
REQ-014 SHALL advance HCOUNT (10 bit) on each tick, wrapping H_TOTAL-1 -> 0; VCOUNT (10 bit) increments on HCOUNT wrap, wrapping V_TOTAL-1 -> 0.
REQ-015 SHALL treat horizontal regions as: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-016 SHALL treat vertical regions as: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-017 SHALL drive VGA_ADDR combinationally as {VCOUNT[8:2], HCOUNT[9:2]} (160x120 region of the 256x128 buffer, 4x4 pixel replication).
REQ-018 SHALL register VGA_HS, VGA_VS and VGA_COLOUR on the tick, from the counter values and VGA_DATA of the pixel addressed since the previous tick; total latency is one pixel period, with sync and colour mutually aligned.
REQ-019 SHALL set VGA_COLOUR to CONFIG_COLOURS[15:8] when the pixel is visible and VGA_DATA=1, CONFIG_COLOURS[7:0] when visible and VGA_DATA=0, and 8'h00 otherwise.
REQ-020 SHALL sample CONFIG_COLOURS per pixel, so a change takes effect at the next tick without tearing mid-pixel.
REQ-021 SHALL pulse VBLANK_START for exactly one CLK, on the tick where the counters become (H=0, V=480).
REQ-022 SHALL rely on VGA_ADDR being driven outside the visible region but SHALL ignore VGA_DATA there.

Reset
REQ-023 SHALL, on RESET_N low, asynchronously clear divider, HCOUNT and VCOUNT to 0, set VGA_HS=1 and VGA_VS=1, and set VGA_COLOUR=0 and VBLANK_START=0.
REQ-024 SHALL make the first tick after RESET_N rises occur PIX_DIV CLKs later; reset mid-frame restarts the frame at (0,0) with no partial sync pulse.

Structure
REQ-025 SHALL place region boundary constants (visible, porch, sync edges for H and V) and the colour-word field positions in shared package vga_pkg.
REQ-026 SHALL implement the divider and H/V counters in one sub-module, vga_timing_gen, exporting tick, HCOUNT, VCOUNT and the visible/sync flags; colour and output registers stay in the top module.

Verification
REQ-027 SHALL cover this case: after reset, count CLKs between VGA_HS falling edges -> 3200 CLKs; HS low for 384 CLKs.
REQ-028 SHALL cover this case: count VGA_VS falling edges -> period 1,680,000 CLKs; VS low for 2 lines (6400 CLKs).
REQ-029 SHALL cover this case: buffer model with Mem[15'h0000]=1 and Mem[15'h0001]=0, CONFIG_COLOURS=16'hFF03 -> pixels 0-3 of line 0 show 8'hFF, pixels 4-7 show 8'h03.
REQ-030 SHALL cover this case: VGA_DATA held at 1 throughout -> VGA_COLOUR=0 for HCOUNT 640-799 and for lines 480-524.
REQ-031 SHALL cover this case: VBLANK_START -> a single one-CLK pulse per frame, coinciding with the counters at (0,480).
REQ-032 SHALL cover this case: RESET_N asserted at line 300 -> all outputs reach reset values immediately; after release the next HS falling edge is 656*4+4 CLKs later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants and colour-word layout for the frame scanner.
package vga_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;

    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;

    // CONFIG_COLOURS layout: foreground in the upper byte, background in the lower byte.
    localparam int unsigned COLOUR_W = 8;
    localparam int unsigned FG_LSB   = 8;
    localparam int unsigned BG_LSB   = 0;

    function automatic logic [COLOUR_W-1:0] pick_colour(input logic pix, input logic [15:0] cfg);
        return pix ? cfg[FG_LSB +: COLOUR_W] : cfg[BG_LSB +: COLOUR_W];
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider plus horizontal/vertical raster counters with region flags.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV = 4,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       h_visible,
    output logic       v_visible,
    output logic       h_sync,
    output logic       v_sync
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign hcount    = h_q;
    assign vcount    = v_q;
    assign h_visible = (h_q < H_VISIBLE);
    assign v_visible = (v_q < V_VISIBLE);
    assign h_sync    = (h_q >= H_SYNC_START) && (h_q < H_SYNC_END);
    assign v_sync    = (v_q >= V_SYNC_START) && (v_q < V_SYNC_END);

endmodule

// File: rtl/vga_frame_scanner.sv
// Scans a 1-bit 256x128 frame buffer onto a 640x480 VGA raster with 4x4 pixel replication.
module vga_frame_scanner
    import vga_pkg::*;
#(
    parameter int PIX_DIV = 4,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] CONFIG_COLOURS,
    input  logic        VGA_DATA,
    output logic [14:0] VGA_ADDR,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [7:0]  VGA_COLOUR,
    output logic        VBLANK_START
);

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_VIS  = V_VISIBLE - 10'd1;

    logic       tick;
    logic [9:0] hcount, vcount;
    logic       h_visible, v_visible, h_sync, v_sync;

    vga_timing_gen #(
        .PIX_DIV (PIX_DIV),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_timing (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .tick      (tick),
        .hcount    (hcount),
        .vcount    (vcount),
        .h_visible (h_visible),
        .v_visible (v_visible),
        .h_sync    (h_sync),
        .v_sync    (v_sync)
    );

    // Address is held for a whole pixel period, so VGA_DATA is settled by the next tick.
    assign VGA_ADDR = {vcount[8:2], hcount[9:2]};

    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic [7:0] colour_q, colour_d;
    logic       vblank_q, vblank_d;

    always_comb begin
        hs_d     = hs_q;
        vs_d     = vs_q;
        colour_d = colour_q;
        vblank_d = 1'b0;
        if (tick) begin
            hs_d     = ~h_sync;
            vs_d     = ~v_sync;
            colour_d = (h_visible && v_visible) ? pick_colour(VGA_DATA, CONFIG_COLOURS) : 8'h00;
            // Counters move to (0, V_VISIBLE) on this same edge.
            vblank_d = (hcount == H_LAST) && (vcount == V_LAST_VIS);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            colour_q <= 8'h00;
            vblank_q <= 1'b0;
        end else begin
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            colour_q <= colour_d;
            vblank_q <= vblank_d;
        end
    end

    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_COLOUR   = colour_q;
    assign VBLANK_START = vblank_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench: full-size instance for line timing, shortened-line instance for frame timing.
module tb_vga_frame_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] cfg;
    logic        data_a, data_b;
    logic [14:0] addr_a, addr_b;
    logic        hs_a, vs_a, hs_b, vs_b;
    logic [7:0]  col_a, col_b;
    logic        vb_a, vb_b;

    vga_frame_scanner #(.PIX_DIV(4), .H_TOTAL(800), .V_TOTAL(525)) dut_a (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .CONFIG_COLOURS (cfg),
        .VGA_DATA       (data_a),
        .VGA_ADDR       (addr_a),
        .VGA_HS         (hs_a),
        .VGA_VS         (vs_a),
        .VGA_COLOUR     (col_a),
        .VBLANK_START   (vb_a)
    );

    // Short lines keep a whole frame (40 x 525 clocks) inside the run.
    vga_frame_scanner #(.PIX_DIV(1), .H_TOTAL(40), .V_TOTAL(525)) dut_b (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .CONFIG_COLOURS (cfg),
        .VGA_DATA       (data_b),
        .VGA_ADDR       (addr_b),
        .VGA_HS         (hs_b),
        .VGA_VS         (vs_b),
        .VGA_COLOUR     (col_b),
        .VBLANK_START   (vb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit mem [0:32767];

    int n_vec = 0;
    int n_err = 0;
    int n     = 0;
    int gcyc  = 0;
    int phase = 0;

    logic [15:0] cfg_edge;
    logic        data_a_edge, data_b_edge, rst_edge;
    logic [7:0]  hold_a = 8'h00, hold_b = 8'h00;
    logic [25:0] exp_a, exp_b;

    logic prev_hs_a = 1'b1, prev_vs_b = 1'b1;
    int   last_fall_a = -1, last_fall_b = -1;
    int   nper_a = 0, nlow_a = 0, nper_b = 0, nlow_b = 0;
    int   vb_cnt_b = 0, nblank_a = 0, nblank_b = 0;
    bit   first_fall_pending = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs after edge n since reset release, from raster arithmetic alone.
    task automatic model_dut(input int p, input int hh, input int vv, input int nn,
                             input logic [15:0] cfg_e, inout logic [7:0] col_hold,
                             output logic [25:0] exp);
        int t, i, h, v, ht, vt;
        logic hs, vs, vb;
        logic [14:0] ad, ma;
        t  = nn / p;
        ht = t % hh;
        vt = (t / hh) % vv;
        ad = {7'(vt >> 2), 8'(ht >> 2)};
        hs = 1'b1;
        vs = 1'b1;
        vb = 1'b0;
        if (t > 0) begin
            i  = t - 1;
            h  = i % hh;
            v  = (i / hh) % vv;
            hs = !(h >= 656 && h < 752);
            vs = !(v >= 490 && v < 492);
            if (nn % p == 0) begin
                ma = {7'(v >> 2), 8'(h >> 2)};
                if (h < 640 && v < 480)
                    col_hold = mem[ma] ? cfg_e[15:8] : cfg_e[7:0];
                else
                    col_hold = 8'h00;
                vb = (ht == 0 && vt == 480);
            end
        end else begin
            col_hold = 8'h00;
        end
        exp = {hs, vs, col_hold, vb, ad};
    endtask

    task automatic step();
        int i, h, v;
        cfg_edge    = cfg;
        data_a_edge = data_a;
        data_b_edge = data_b;
        rst_edge    = rst_n;
        @(posedge clk);
        #1;
        gcyc++;
        n = rst_edge ? n + 1 : 0;

        model_dut(4, 800, 525, n, cfg_edge, hold_a, exp_a);
        model_dut(1, 40, 525, n, cfg_edge, hold_b, exp_b);
        if (n_err < 40) begin
            chk($sformatf("a_cyc@%0d", n), {6'd0, hs_a, vs_a, col_a, vb_a, addr_a}, {6'd0, exp_a});
            chk($sformatf("b_cyc@%0d", n), {6'd0, hs_b, vs_b, col_b, vb_b, addr_b}, {6'd0, exp_b});
        end

        if (phase == 1 && n >= 5 && n <= 33 && (n % 4) == 1)
            chk($sformatf("line0_px%0d", (n - 5) / 4), {24'd0, col_a}, (n <= 17) ? 32'hFF : 32'h03);

        if (n >= 4 && (n % 4) == 0 && data_a_edge && nblank_a < 20) begin
            i = n / 4 - 1;
            h = i % 800;
            if (h >= 640) begin
                chk("a_hblank_d1", {24'd0, col_a}, 32'h0);
                nblank_a++;
            end
        end
        if (n >= 1 && data_b_edge && nblank_b < 20) begin
            v = ((n - 1) / 40) % 525;
            if (v >= 480) begin
                chk("b_vblank_d1", {24'd0, col_b}, 32'h0);
                nblank_b++;
            end
        end

        if (n == 0) begin
            prev_hs_a          = 1'b1;
            prev_vs_b          = 1'b1;
            last_fall_a        = -1;
            last_fall_b        = -1;
            first_fall_pending = 1'b1;
        end else begin
            if (prev_hs_a && !hs_a) begin
                if (first_fall_pending) begin
                    chk("a_hs_first_fall", n, 2628);
                    first_fall_pending = 1'b0;
                end
                if (last_fall_a >= 0 && nper_a < 3) begin
                    chk("a_hs_period", gcyc - last_fall_a, 3200);
                    nper_a++;
                end
                last_fall_a = gcyc;
            end
            if (!prev_hs_a && hs_a && last_fall_a >= 0 && nlow_a < 3) begin
                chk("a_hs_low", gcyc - last_fall_a, 384);
                nlow_a++;
            end
            if (vb_b) vb_cnt_b++;
            if (prev_vs_b && !vs_b) begin
                if (last_fall_b >= 0 && nper_b < 2) begin
                    chk("b_vs_period", gcyc - last_fall_b, 21000);
                    chk("b_vblank_per_frame", vb_cnt_b, 1);
                    nper_b++;
                end
                last_fall_b = gcyc;
                vb_cnt_b    = 0;
            end
            if (!prev_vs_b && vs_b && last_fall_b >= 0 && nlow_b < 2) begin
                chk("b_vs_low", gcyc - last_fall_b, 80);
                nlow_b++;
            end
            prev_hs_a = hs_a;
            prev_vs_b = vs_b;
        end

        data_a = mem[addr_a];
        data_b = mem[addr_b];
    endtask

    initial begin
        rst_n  = 1'b0;
        cfg    = 16'hFF03;
        data_a = 1'b0;
        data_b = 1'b0;
        for (int k = 0; k < 32768; k++) mem[k] = 1'($urandom);
        mem[0] = 1'b1;
        mem[1] = 1'b0;

        repeat (3) step();
        chk("rst_state_a", {6'd0, hs_a, vs_a, col_a, vb_a, addr_a}, {6'd0, 2'b11, 8'h00, 1'b0, 15'h0});
        chk("rst_state_b", {6'd0, hs_b, vs_b, col_b, vb_b, addr_b}, {6'd0, 2'b11, 8'h00, 1'b0, 15'h0});

        phase = 1;
        rst_n = 1'b1;
        for (int k = 0; k < 41000; k++) begin
            step();
            if (k >= 100 && $urandom_range(0, 15) == 0) cfg = 16'($urandom);
        end

        // Reset lands inside an HS pulse; outputs must clear without waiting for a clock.
        phase = 2;
        for (int k = 0; k < 4000 && hs_a; k++) step();
        chk("a_hs_wait", {31'd0, hs_a}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_a", {6'd0, hs_a, vs_a, col_a, vb_a, addr_a}, {6'd0, 2'b11, 8'h00, 1'b0, 15'h0});
        chk("rst_async_b", {6'd0, hs_b, vs_b, col_b, vb_b, addr_b}, {6'd0, 2'b11, 8'h00, 1'b0, 15'h0});
        repeat (3) step();
        rst_n = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            step();
            if ($urandom_range(0, 15) == 0) cfg = 16'($urandom);
        end
        chk("a_hs_after_reset", {31'd0, first_fall_pending}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
